// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scan capture block: segment code table,
// blank pattern, FSM state encoding and small an-bus helpers.
package seg_scan_pkg;

    // Active-low a..g as {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SETTLE = 2'd1;
    localparam state_t HOLD   = 2'd2;

    // True when exactly one anode enable is asserted (low).
    function automatic logic one_cold(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    // Position of the lowest zero bit; only meaningful when one_cold(v).
    function automatic logic [1:0] cold_index(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-7-segment decoder: active-low a..g to
// hex digit, with blank and error flags.
module seg7_to_hex
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       blank,
    output logic       err
);

    always_comb begin
        hex   = 4'h0;
        blank = (seg == SEG_BLANK);
        err   = !blank;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                hex = 4'(i);
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds 4-digit hex frames from a multiplexed active-low anode/segment bus.
// Optional glitch counter output enabled by defining SEG_SCAN_GLITCH_CNT_EN.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] hex,
    output logic [3:0]  points,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic        no_signal
`ifdef SEG_SCAN_GLITCH_CNT_EN
    ,
    output logic [15:0] glitch_cnt
`endif
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    logic [3:0]    s_an, p_an;
    logic [7:0]    s_seg, p_seg;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    state_t        state_q, state_d;

    logic [3:0]    mask_q, mask_d;
    logic [15:0]   slot_hex_q, slot_hex_d;
    logic [3:0]    slot_p_q, slot_p_d;
    logic [3:0]    slot_blank_q, slot_blank_d;
    logic [3:0]    slot_err_q, slot_err_d;
    logic          no_signal_d;

    logic          change, an_ok, accept, frame, timeout;
    logic [1:0]    idx;
    logic [3:0]    dec_hex;
    logic          dec_blank, dec_err;

    assign change = ({s_an, s_seg} != {p_an, p_seg});
    assign an_ok  = one_cold(s_an);
    assign idx    = cold_index(s_an);

    seg7_to_hex u_dec (
        .seg   (s_seg[6:0]),
        .hex   (dec_hex),
        .blank (dec_blank),
        .err   (dec_err)
    );

    // Input stage and stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_an  <= 4'hF;
            s_seg <= 8'hFF;
            p_an  <= 4'hF;
            p_seg <= 8'hFF;
            cnt_q <= '0;
        end else begin
            s_an  <= an;
            s_seg <= seg;
            p_an  <= s_an;
            p_seg <= s_seg;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        if (change) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (an_ok) state_d = SETTLE;
            end
            SETTLE: begin
                if (!an_ok) begin
                    state_d = IDLE;
                end else if (!change && cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!an_ok) begin
                    state_d = IDLE;
                end else if (change) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        accept = (state_q == SETTLE) && an_ok && !change && (cnt_q == CNT_LAST);
    end

    // Slot capture, frame assembly and idle timeout.
    always_comb begin
        slot_hex_d   = slot_hex_q;
        slot_p_d     = slot_p_q;
        slot_blank_d = slot_blank_q;
        slot_err_d   = slot_err_q;
        mask_d       = mask_q;
        frame        = 1'b0;
        timeout      = 1'b0;
        idle_d       = idle_q;
        no_signal_d  = no_signal;

        if (accept) begin
            slot_hex_d[{idx, 2'b00} +: 4] = dec_hex;
            slot_p_d[idx]                 = ~s_seg[7];
            slot_blank_d[idx]             = dec_blank;
            slot_err_d[idx]               = dec_err;
            mask_d                        = mask_q | (4'b0001 << idx);
            // The completing digit is already in the *_d slots emitted below.
            if (mask_d == 4'hF) begin
                frame  = 1'b1;
                mask_d = 4'h0;
            end
            idle_d      = '0;
            no_signal_d = 1'b0;
        end else if (idle_q == IDLE_LAST) begin
            timeout     = 1'b1;
            mask_d      = 4'h0;
            no_signal_d = 1'b1;
        end else begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q       <= 4'h0;
            slot_hex_q   <= 16'h0;
            slot_p_q     <= 4'h0;
            slot_blank_q <= 4'hF;
            slot_err_q   <= 4'h0;
            idle_q       <= '0;
            no_signal    <= 1'b1;
            hex          <= 16'h0;
            points       <= 4'h0;
            blank        <= 4'hF;
            err          <= 4'h0;
            frame_valid  <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            slot_hex_q   <= slot_hex_d;
            slot_p_q     <= slot_p_d;
            slot_blank_q <= slot_blank_d;
            slot_err_q   <= slot_err_d;
            idle_q       <= idle_d;
            no_signal    <= no_signal_d;
            frame_valid  <= frame;
            if (frame) begin
                hex    <= slot_hex_d;
                points <= slot_p_d;
                blank  <= slot_blank_d;
                err    <= slot_err_d;
            end
        end
    end

`ifdef SEG_SCAN_GLITCH_CNT_EN
    logic glitch_inc;

    // Any change seen while settling abandons that digit without an accept.
    assign glitch_inc = (state_q == SETTLE) && change;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= 16'h0;
        end else if (glitch_inc && glitch_cnt != 16'hFFFF) begin
            glitch_cnt <= glitch_cnt + 16'h1;
        end
    end
`endif

endmodule
